// File: rtl/hilo_mult_sequencer_if.sv
// HI/LO multiply sequencer bus: request side (Start, ALUControl, operands)
// and result side (Busy, Done, architectural HI/LO).
interface hilo_mult_sequencer_if;
    logic        Start;
    logic [5:0]  ALUControl;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Done;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output Start, ALUControl, A, B,
        input  Busy, Done, HI, LO
    );

    modport slave (
        input  Start, ALUControl, A, B,
        output Busy, Done, HI, LO
    );
endinterface

// File: rtl/hilo_mult_sequencer.sv
// Sequential 32x32 multiplier owning the architectural HI/LO pair; handles
// MULT/MULTU/MADD/MSUB with fixed 33-cycle latency plus single-cycle MTHI/MTLO.
module hilo_mult_sequencer (
    input  logic                  Clk,
    input  logic                  Rst,
    hilo_mult_sequencer_if.slave  bus
);
    localparam int DATA_W = 32;
    localparam int PROD_W = 2 * DATA_W;

    localparam logic [5:0] OP_MULT  = 6'b000011;
    localparam logic [5:0] OP_MULTU = 6'b000100;
    localparam logic [5:0] OP_MADD  = 6'b010100;
    localparam logic [5:0] OP_MSUB  = 6'b010101;
    localparam logic [5:0] OP_MTHI  = 6'b011001;
    localparam logic [5:0] OP_MTLO  = 6'b011010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [4:0]          cnt;
    logic [PROD_W-1:0]   prod;
    logic [DATA_W-1:0]   mcand;
    logic [5:0]          op;
    logic                neg;
    logic                done_q;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;

    logic                start_mul;
    logic                mt_hi;
    logic                mt_lo;
    logic                op_in_signed;
    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;
    logic [DATA_W:0]     step_sum;
    logic [PROD_W-1:0]   signed_prod;
    logic [PROD_W-1:0]   hilo_nxt;

    function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] x);
        // -(-2^31) wraps back to 0x80000000, which is the correct unsigned magnitude
        return x[DATA_W-1] ? DATA_W'(-x) : DATA_W'(x);
    endfunction

    function automatic logic [PROD_W-1:0] apply_sign(input logic [PROD_W-1:0] p, input logic n);
        return n ? (~p + PROD_W'(1)) : p;
    endfunction

    function automatic logic is_mul_op(input logic [5:0] code);
        return (code == OP_MULT) || (code == OP_MULTU) ||
               (code == OP_MADD) || (code == OP_MSUB);
    endfunction

    assign op_in_signed = (bus.ALUControl != OP_MULTU);
    assign mag_a        = op_in_signed ? magnitude($signed(bus.A)) : bus.A;
    assign mag_b        = op_in_signed ? magnitude($signed(bus.B)) : bus.B;

    // Radix-2 step: add multiplicand into the upper half when the current
    // multiplier bit (prod[0]) is set, then shift the whole product right.
    assign step_sum    = {1'b0, prod[PROD_W-1:DATA_W]} + (prod[0] ? {1'b0, mcand} : '0);
    assign signed_prod = apply_sign(prod, neg);

    always_comb begin
        hilo_nxt = signed_prod;
        case (op)
            OP_MADD: hilo_nxt = {hi_q, lo_q} + signed_prod;
            OP_MSUB: hilo_nxt = {hi_q, lo_q} - signed_prod;
            default: hilo_nxt = signed_prod;
        endcase
    end

    always_comb begin
        state_nxt = state;
        start_mul = 1'b0;
        mt_hi     = 1'b0;
        mt_lo     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Start) begin
                    if (is_mul_op(bus.ALUControl)) begin
                        start_mul = 1'b1;
                        state_nxt = MUL;
                    end else if (bus.ALUControl == OP_MTHI) begin
                        mt_hi = 1'b1;
                    end else if (bus.ALUControl == OP_MTLO) begin
                        mt_lo = 1'b1;
                    end
                end
            end
            MUL:     if (cnt == 5'd0) state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt    <= 5'd0;
            prod   <= '0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_mul) begin
                        cnt  <= 5'd31;
                        prod <= {{DATA_W{1'b0}}, mag_b};
                    end
                    if (mt_hi) begin
                        hi_q   <= bus.A;
                        done_q <= 1'b1;
                    end
                    if (mt_lo) begin
                        lo_q   <= bus.A;
                        done_q <= 1'b1;
                    end
                end
                MUL: begin
                    prod <= {step_sum, prod[DATA_W-1:1]};
                    cnt  <= (cnt == 5'd0) ? 5'd0 : cnt - 5'd1;
                end
                WB: begin
                    {hi_q, lo_q} <= hilo_nxt;
                    done_q       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Operand latch: only loaded on an accepted multiply, so requests made
    // while busy can never disturb the operation in flight.
    always_ff @(posedge Clk) begin
        if (start_mul) begin
            mcand <= mag_a;
            op    <= bus.ALUControl;
            neg   <= op_in_signed & (bus.A[DATA_W-1] ^ bus.B[DATA_W-1]);
        end
    end

    assign bus.Busy = (state != IDLE);
    assign bus.Done = done_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule

// File: tb/tb_hilo_mult_sequencer.sv
// Bench for hilo_mult_sequencer: latency/arithmetic reference model checked every
// cycle, plus directed scenarios with hand-computed HI/LO values.
module tb_hilo_mult_sequencer;
    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_MULT  = 6'b000011;
    localparam logic [5:0] OP_MULTU = 6'b000100;
    localparam logic [5:0] OP_MADD  = 6'b010100;
    localparam logic [5:0] OP_MSUB  = 6'b010101;
    localparam logic [5:0] OP_MTHI  = 6'b011001;
    localparam logic [5:0] OP_MTLO  = 6'b011010;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    hilo_mult_sequencer_if bus ();

    hilo_mult_sequencer dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a multiply result appears 33 edges after acceptance.
    logic [63:0] m_hilo = '0;
    logic        m_done = 1'b0;
    int          m_left = 0;
    logic [5:0]  m_op   = '0;
    logic [31:0] m_a    = '0;
    logic [31:0] m_b    = '0;

    function automatic logic [63:0] model_result(input logic [5:0] op, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [63:0] hilo);
        logic signed [63:0] sa, sb, sp;
        logic [63:0] up;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        sp = sa * sb;
        up = {32'b0, a} * {32'b0, b};
        case (op)
            OP_MULT:  return sp;
            OP_MULTU: return up;
            OP_MADD:  return hilo + sp;
            OP_MSUB:  return hilo - sp;
            default:  return hilo;
        endcase
    endfunction

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            m_hilo = '0;
            m_done = 1'b0;
            m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hilo = model_result(m_op, m_a, m_b, m_hilo);
                    m_done = 1'b1;
                end
            end else if (bus.Start) begin
                case (bus.ALUControl)
                    OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                        m_op = bus.ALUControl;
                        m_a  = bus.A;
                        m_b  = bus.B;
                        m_left = 33;
                    end
                    OP_MTHI: begin m_hilo[63:32] = bus.A; m_done = 1'b1; end
                    OP_MTLO: begin m_hilo[31:0]  = bus.A; m_done = 1'b1; end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge Clk) begin
        check("busy", 64'(bus.Busy), 64'(m_left > 0));
        check("done", 64'(bus.Done), 64'(m_done));
        check("hi",   64'(bus.HI),   64'(m_hilo[63:32]));
        check("lo",   64'(bus.LO),   64'(m_hilo[31:0]));
    end

    // Issue one request at the current negedge and follow it to Done.
    task automatic run_op(input string name, input logic [5:0] code, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int k;
        int busy_n;
        bus.Start = 1'b1;
        bus.ALUControl = code;
        bus.A = a;
        bus.B = b;
        @(negedge Clk);
        bus.Start = 1'b0;
        k = 0;
        busy_n = 0;
        while (!bus.Done && k < 40) begin
            if (bus.Busy) busy_n++;
            @(negedge Clk);
            k++;
        end
        check({name, "_latency"}, 64'(k), 64'(exp_lat));
        check({name, "_busy_cycles"}, 64'(busy_n), 64'(exp_lat));
        check({name, "_hi"}, 64'(bus.HI), 64'(exp_hi));
        check({name, "_lo"}, 64'(bus.LO), 64'(exp_lo));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dn;
        logic [31:0] lo_seen;
        bus.Start = 1'b0;
        bus.ALUControl = '0;
        bus.A = '0;
        bus.B = '0;
        repeat (2) @(negedge Clk);
        check("rst_hi",   64'(bus.HI),   64'h0);
        check("rst_lo",   64'(bus.LO),   64'h0);
        check("rst_busy", 64'(bus.Busy), 64'h0);
        check("rst_done", 64'(bus.Done), 64'h0);
        Rst = 1'b0;

        run_op("mult_7x6", OP_MULT, 32'd7, 32'd6, 33, 32'h0000_0000, 32'h0000_002A);
        @(negedge Clk);
        check("mult_7x6_done_pulse", 64'(bus.Done), 64'h0);

        run_op("mult_m1x2", OP_MULT, 32'hFFFF_FFFF, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001);

        run_op("mthi", OP_MTHI, 32'd0, 32'd0, 0, 32'h0000_0000, 32'h0000_0001);
        run_op("mtlo", OP_MTLO, 32'd10, 32'd0, 0, 32'h0000_0000, 32'h0000_000A);
        run_op("madd", OP_MADD, 32'd3, 32'hFFFF_FFFE, 33, 32'h0000_0000, 32'h0000_0004);
        run_op("msub", OP_MSUB, 32'd2, 32'd2, 33, 32'h0000_0000, 32'h0000_0000);

        run_op("mult_min_sq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000, 32'h0000_0000);
        run_op("mult_min_x1", OP_MULT, 32'h8000_0000, 32'd1, 33, 32'hFFFF_FFFF, 32'h8000_0000);

        // Second request while busy must be dropped
        bus.Start = 1'b1;
        bus.ALUControl = OP_MULT;
        bus.A = 32'd5;
        bus.B = 32'd5;
        @(negedge Clk);
        dn = 0;
        lo_seen = '0;
        for (int k = 0; k < 45; k++) begin
            if (k == 10) begin
                bus.Start = 1'b1;
                bus.ALUControl = OP_MULTU;
                bus.A = 32'd9;
                bus.B = 32'd9;
            end else begin
                bus.Start = 1'b0;
            end
            if (bus.Done) begin
                dn++;
                lo_seen = bus.LO;
            end
            @(negedge Clk);
        end
        check("busy_ignore_dones", 64'(dn), 64'd1);
        check("busy_ignore_lo", 64'(lo_seen), 64'h19);
        check("busy_ignore_hi", 64'(bus.HI), 64'h0);

        // Reset in the middle of a multiply
        bus.Start = 1'b1;
        bus.ALUControl = OP_MULT;
        bus.A = 32'd100;
        bus.B = 32'd100;
        @(negedge Clk);
        bus.Start = 1'b0;
        repeat (20) @(negedge Clk);
        #2 Rst = 1'b1;
        #1;
        check("abort_busy", 64'(bus.Busy), 64'h0);
        check("abort_done", 64'(bus.Done), 64'h0);
        check("abort_hi",   64'(bus.HI),   64'h0);
        check("abort_lo",   64'(bus.LO),   64'h0);
        @(negedge Clk);
        #2 Rst = 1'b0;
        @(negedge Clk);
        dn = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.Done) dn++;
            @(negedge Clk);
        end
        check("abort_no_done", 64'(dn), 64'd0);
        run_op("mult_3x3", OP_MULT, 32'd3, 32'd3, 33, 32'h0000_0000, 32'h0000_0009);

        // Non-HI/LO ALU code is ignored
        run_op("mthi_pat", OP_MTHI, 32'hDEAD_BEEF, 32'd0, 0, 32'hDEAD_BEEF, 32'h0000_0009);
        run_op("mtlo_pat", OP_MTLO, 32'h1234_5678, 32'd0, 0, 32'hDEAD_BEEF, 32'h1234_5678);
        bus.Start = 1'b1;
        bus.ALUControl = OP_ADD;
        bus.A = 32'd55;
        bus.B = 32'd66;
        @(negedge Clk);
        bus.Start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("add_busy", 64'(bus.Busy), 64'h0);
            check("add_done", 64'(bus.Done), 64'h0);
            check("add_hi",   64'(bus.HI),   64'hDEAD_BEEF);
            check("add_lo",   64'(bus.LO),   64'h1234_5678);
            @(negedge Clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hilo_mult_sequencer.md
HILO_MULT_SEQUENCER -- requirements
Module: hilo_mult_sequencer

Interface
REQ-001 The block SHALL expose these parameters: none; all widths are fixed at a 32-bit operand and a 6-bit control code.
REQ-002 The block SHALL have port Clk, input, 1: single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Rst, input, 1: reset, asynchronous, active-high.
REQ-004 The block SHALL have port Start, input, 1: request strobe, sampled on rising Clk.
REQ-005 The block SHALL have port ALUControl, input, 6: operation code in the team's 6-bit ALU control encoding, sampled with Start.
REQ-006 The block SHALL have ports A and B, input, 32 each: operands (rs, rt), sampled with Start.
REQ-007 The block SHALL have port Busy, output, 1: high while a multiply is in progress; the pipeline stalls HI/LO users on it.
REQ-008 The block SHALL have port Done, output, 1: one-cycle pulse marking the cycle in which HI/LO first show a new result.
REQ-009 The block SHALL have ports HI and LO, output, 32 each: architectural HI/LO registers, driven directly from flops.

Function
REQ-010 The block SHALL accept these codes: MULT=000011 (signed), MULTU=000100 (unsigned), MADD=010100 (signed accumulate), MSUB=010101 (signed subtract-accumulate), MTHI=011001, MTLO=011010.
REQ-011 The block SHALL ignore any other code with Start=1: no state change, no Done.
REQ-012 The block SHALL implement FSM states IDLE, MUL and WB, with Busy = (state != IDLE).
REQ-013 IDLE, on Start with a multiply code, SHALL latch the operands and the op and go to MUL; the cycle counter SHALL load 31.
REQ-014 For signed ops, the latched operands SHALL be magnitudes and the result sign SHALL be A[31]^B[31].
REQ-015 MUL SHALL do one radix-2 shift-add step per cycle into a 64-bit unsigned product.
REQ-016 MUL SHALL decrement the counter each cycle and go to WB after the step taken with counter=0, i.e. exactly 32 MUL cycles.
REQ-017 WB SHALL, on its closing edge, first negate the product if the sign bit is set (signed ops only), then write {HI,LO} as follows:
- MULT/MULTU: product.
- MADD: {HI,LO}+product.
- MSUB: {HI,LO}-product.
All arithmetic SHALL be modulo 2^64.
REQ-018 On the same WB closing edge, Done SHALL be set to 1 for exactly one cycle and the state SHALL return to IDLE.
REQ-019 Latency SHALL be fixed: with Start sampled at edge 0, Busy is high from edge 0 to edge 33, and HI/LO update with Done=1 at edge 33. There is no early termination for small operands.
REQ-020 MTHI/MTLO in IDLE SHALL write A into HI/LO respectively at the sampling edge, leave Busy low, and set Done for one cycle.
REQ-021 The block SHALL ignore Start while Busy=1; latched operands SHALL NOT change.
REQ-022 The block SHALL accept Start in the IDLE cycle where Done=1, so back-to-back operations are possible, with no bubble required.
REQ-023 MADD/MSUB SHALL accumulate onto the HI/LO value present at the WB edge, including any result written by a just-completed prior operation.
REQ-024 HI/LO SHALL hold their values throughout MUL; reads during Busy return the old value, and stalling is the consumer's responsibility.

Reset
REQ-025 While Rst=1, the block SHALL hold state=IDLE, counter=0, Busy=0, Done=0, HI=0, LO=0 and product=0, independent of Clk.
REQ-026 Rst asserted mid-MUL or mid-WB SHALL abort the operation: no HI/LO write and no Done, with the block restarting in IDLE after release.
REQ-027 The first Start SHALL be honoured on the first rising edge after Rst deasserts.

Verification
REQ-028 The bench SHALL cover: MULT A=7, B=6 -> Busy high for 33 cycles; at edge 33 HI=00000000, LO=0000002A, Done=1 for 1 cycle.
REQ-029 The bench SHALL cover: MULT A=FFFFFFFF (-1), B=2 -> HI=FFFFFFFF, LO=FFFFFFFE; followed by MULTU A=B=FFFFFFFF -> HI=FFFFFFFE, LO=00000001.
REQ-030 The bench SHALL cover: MTHI A=0, MTLO A=10, then MADD A=3, B=-2 -> HI=00000000, LO=00000004; then MSUB A=B=2 -> HI=LO=00000000.
REQ-031 The bench SHALL cover: MULT 5x5 with a second Start (MULTU 9x9) pulsed at cycle 10 -> second request ignored; result LO=00000019, single Done.
REQ-032 The bench SHALL cover: MULT 100x100 with Rst pulsed at cycle 20 -> HI=LO=0, Busy=0, no Done; a subsequent MULT 3x3 completes with LO=00000009 at 33 cycles.
REQ-033 The bench SHALL cover: ALUControl=000000 (ADD) with Start -> no Busy, no Done, HI/LO unchanged.
